// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-neuron tile: default datapath width and
// the saturating add/subtract used by the synapse and the neuron current input.
package snn_pkg;

    localparam int SNN_WIDTH = 8;

    // Operands are zero-extended to 32 bits; the result is {clamped, value}
    // with value confined to [0, 2^width-1]. Intended for width < 32.
    function automatic logic [32:0] sat_addsub(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic        sub,
        input int unsigned width
    );
        logic [32:0] sum;
        logic [31:0] max_val;
        max_val    = (32'd1 << width) - 32'd1;
        sum        = {1'b0, a} + {1'b0, b};
        sat_addsub = {1'b0, 32'd0};
        if (sub) begin
            if (b > a) begin
                sat_addsub = {1'b1, 32'd0};
            end else begin
                sat_addsub = {1'b0, a - b};
            end
        end else begin
            if (sum > {1'b0, max_val}) begin
                sat_addsub = {1'b1, max_val};
            end else begin
                sat_addsub = {1'b0, sum[31:0]};
            end
        end
    endfunction

endpackage

// File: rtl/synapse_prescaler.sv
// Decay-rate prescaler: counts enabled cycles and pulses tick once every
// PRESCALE of them. The count freezes while ena is low.
module synapse_prescaler #(
    parameter int PRESCALE = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    output logic tick
);

    localparam int            CW   = $clog2(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    assign tick = ena && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else if (ena) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/spike_synapse.sv
// Synaptic front end: turns rising edges of an upstream spike into a weighted,
// exponentially decaying, saturating input current for a downstream neuron.
module spike_synapse
    import snn_pkg::*;
#(
    parameter int WIDTH       = SNN_WIDTH,
    parameter int DECAY_SHIFT = 3,
    parameter int PRESCALE    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             spike_in,
    input  logic [WIDTH-1:0] weight,
    input  logic             inhibit,
    output logic [WIDTH-1:0] current,
    output logic [7:0]       event_count,
    output logic             sat
);

    logic             spike_q;
    logic             spike_event;
    logic             tick;
    logic [WIDTH-1:0] decay_step;
    logic [WIDTH-1:0] decayed;
    logic [WIDTH-1:0] next_current;
    logic             next_sat;
    logic [32:0]      addsub_res;
    logic             unused_addsub_bits;

    synapse_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .ena  (ena),
        .tick (tick)
    );

    assign spike_event        = ena & spike_in & ~spike_q;
    assign unused_addsub_bits = ^addsub_res[31:WIDTH];

    // Decay first, then apply the event; a minimum step of 1 guarantees the
    // current always drains fully to zero.
    always_comb begin
        decay_step = current >> DECAY_SHIFT;
        if (decay_step == '0 && current != '0) begin
            decay_step = WIDTH'(1);
        end
        decayed      = tick ? current - decay_step : current;
        addsub_res   = sat_addsub(32'(decayed), 32'(weight), inhibit, WIDTH);
        next_current = decayed;
        next_sat     = 1'b0;
        if (spike_event) begin
            next_current = addsub_res[WIDTH-1:0];
            next_sat     = addsub_res[32];
        end
    end

    // spike_q resets high so a spike already asserted at reset release is ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            spike_q     <= 1'b1;
            current     <= '0;
            event_count <= '0;
            sat         <= 1'b0;
        end else begin
            spike_q <= spike_in;
            current <= next_current;
            sat     <= next_sat;
            if (spike_event) begin
                event_count <= event_count + 8'd1;
            end
        end
    end

endmodule

// File: doc/spike_synapse.md
# spike_synapse

Synaptic front end for the spiking-neuron tile. It receives the 1-bit spike output of an upstream neuron and converts it into an 8-bit unsigned input current suitable for driving the current input of a downstream neuron. Each rising edge of the spike adds or subtracts a programmable weight, and the accumulated current decays exponentially at a prescaled rate. Together with the neuron it forms a neuron-to-neuron link: spike in, current out.

## Interface
Parameters:
- WIDTH, 8: current and weight width in bits.
- DECAY_SHIFT, 3: per-tick decay is current >> DECAY_SHIFT. Legal range is 1..WIDTH-1.
- PRESCALE, 16: clock cycles per decay tick. Must be at least 2.

Ports:
- clk  in  1  clock, single clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- ena  in  1  1 = operate; 0 = freeze state.
- spike_in  in  1  spike level from the upstream neuron. A rising edge is one event.
- weight  in  WIDTH  unsigned synaptic weight, sampled on the event cycle.
- inhibit  in  1  0 = event adds weight; 1 = event subtracts weight.
- current  out  WIDTH  registered synaptic current.
- event_count  out  8  number of accepted events, wraps 255 -> 0.
- sat  out  1  one-cycle pulse when the update clamps at 0 or 2^WIDTH-1.

## Operation
- Edge detect:
  - spike_q is a registered copy of spike_in.
  - event = ena & spike_in & ~spike_q.
  - spike_q updates every cycle regardless of ena.
- Prescaler:
  - Counter runs 0..PRESCALE-1.
  - tick = ena & (cnt == PRESCALE-1); cnt wraps to 0 on tick.
  - cnt holds while ena = 0.
- Decay, applied on tick:
  - d = current >> DECAY_SHIFT.
  - If d == 0 and current != 0, d = 1, so the current always reaches 0.
  - decayed = current - d. Without a tick, decayed = current.
- Event update:
  - Computed at WIDTH+1 bits: decayed ± weight.
  - Clamped to [0, 2^WIDTH-1].
  - sat = 1 in the cycle after the clamp is applied, i.e. when the result is actually clamped. Reaching a bound exactly does not assert sat.
- Tick and event in the same cycle: decay first, then weight. Both take effect on one edge.
- ena = 0:
  - current, cnt and event_count hold; sat = 0.
  - A spike edge that occurs while ena = 0 is lost. It is not replayed later.
- event_count increments on every accepted event, including clamped ones.
- Reset values:
  - current = 0, event_count = 0, sat = 0, cnt = 0.
  - spike_q = 1, so a spike_in already high when reset is released is not counted.
- Reset mid-operation: all state returns to reset values on the first clk edge with rst_n = 0. No pending event survives.

## Timing
- Latency from a spike_in rising edge to current is 1 cycle:
  - spike_in = 1 and spike_q = 0 are sampled at edge N.
  - The new current is visible after edge N.
- Ticks occur every PRESCALE cycles of ena = 1, starting PRESCALE cycles after reset release.
- sat is aligned with the current update that clamped.
- No handshake is used. A spike_in held high for many cycles counts as one event. Back-to-back events need spike_in to be low for at least one cycle between them.
- The maximum event rate is one per 2 cycles.

## Structure
- Shared package snn_pkg:
  - WIDTH default constant.
  - Saturating add/subtract function sat_addsub(a, b, sub) returning {clamped, value}.
  - The same package is reused by the neuron's current input path.
- One sub-module, synapse_prescaler: the counter plus the tick output, with PRESCALE as its parameter.
- The edge detect, decay and accumulate logic live in spike_synapse.
- All registers use the synchronous rst_n.

## Test plan
Default parameters (WIDTH=8, DECAY_SHIFT=3, PRESCALE=16) unless noted.
- Reset:
  - Stimulus: hold rst_n = 0 for 2 cycles with spike_in = 1, then release with spike_in still 1.
  - Required: current = 0, event_count = 0, sat = 0; no event counted.
- Excitatory spike and decay:
  - Stimulus: weight = 100, inhibit = 0, one rising edge away from any tick.
  - Required: current = 100 one cycle after the edge, then 88, 77, 68 on successive ticks; event_count = 1.
- Excitatory saturation:
  - Stimulus: weight = 200, two events 2 cycles apart, no tick in between.
  - Required: current goes 200 then 255; sat pulses for exactly 1 cycle, on the second update.
- Inhibitory clamp and floor decay:
  - Stimulus: current = 50, inhibit = 1, weight = 80.
  - Required: current = 0 with a sat pulse.
  - Follow-up: from current = 5 with no events, ticks give 4, 3, 2, 1, 0, and current then stays 0.
- Simultaneous tick and event:
  - Stimulus: current = 80, event with weight = 10 landing on a tick cycle.
  - Required: current = 80 (80 - 10 + 10); event_count increments by 1.
- Enable freeze:
  - Stimulus: current = 60; drop ena for 40 cycles and pulse spike_in during that time.
  - Required: current stays 60 and event_count is unchanged.
  - After ena returns to 1, the first tick arrives 16 - cnt_at_freeze cycles later.
